// File: rtl/matmul_sequencer_if.sv
// Bundles the execute-side op handshake and the systolic-array strobes.
// The sequencer uses the slave view; whoever drives ops and models the array uses master.
interface matmul_sequencer_if #(
  parameter int DIM    = 8,
  parameter int LANES  = 4,
  parameter int DATA_W = 32
) ();
  localparam int IDX_W  = $clog2(DIM);
  localparam int HALF_W = LANES*DATA_W;
  localparam int ROW_W  = DIM*DATA_W;

  // execute side
  logic              op_valid;
  logic [2:0]        op_code;
  logic [IDX_W-1:0]  op_idx;
  logic              op_high_low;
  logic [HALF_W-1:0] vec_lo;
  logic [HALF_W-1:0] vec_hi;
  logic              op_ready;
  logic              res_valid;
  logic [HALF_W-1:0] res_data;
  logic              mm_done;
  logic              illegal_op;
  logic [15:0]       mm_count;

  // array side
  logic              arr_a_we;
  logic              arr_b_we;
  logic              arr_c_we;
  logic [IDX_W-1:0]  arr_row;
  logic [ROW_W-1:0]  arr_wdata;
  logic              arr_step;
  logic              arr_c_re;
  logic [ROW_W-1:0]  arr_c_rdata;

  modport slave (
    input  op_valid, op_code, op_idx, op_high_low, vec_lo, vec_hi, arr_c_rdata,
    output op_ready, res_valid, res_data, mm_done, illegal_op, mm_count,
           arr_a_we, arr_b_we, arr_c_we, arr_row, arr_wdata, arr_step, arr_c_re
  );

  modport master (
    output op_valid, op_code, op_idx, op_high_low, vec_lo, vec_hi, arr_c_rdata,
    input  op_ready, res_valid, res_data, mm_done, illegal_op, mm_count,
           arr_a_we, arr_b_we, arr_c_we, arr_row, arr_wdata, arr_step, arr_c_re
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Matrix-op sequencer: turns execute-stage matrix opcodes into fixed-timing
// systolic array strobes and stalls execute during matmul / readC.
module matmul_sequencer #(
  parameter int DIM    = 8,
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int STEPS  = 3*DIM-2
) (
  input  logic clk,
  input  logic rst,
  matmul_sequencer_if.slave bus
);
  localparam int HALF_W = LANES*DATA_W;
  localparam int IDX_W  = $clog2(DIM);
  localparam int ROW_W  = DIM*DATA_W;
  localparam int CNT_W  = $clog2(STEPS+1);

  localparam logic [2:0] OP_WRA  = 3'b001;
  localparam logic [2:0] OP_WRB  = 3'b010;
  localparam logic [2:0] OP_WRC  = 3'b011;
  localparam logic [2:0] OP_MM   = 3'b100;
  localparam logic [2:0] OP_RDC  = 3'b101;
  localparam logic [2:0] OP_STEP = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RDREQ, S_RDCAP} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               w_acc;
  logic               w_mm_last;

  logic               r_a_we, r_b_we, r_c_we, r_step1, r_hl;
  logic [IDX_W-1:0]   r_row;
  logic [ROW_W-1:0]   r_wdata;
  logic               r_res_valid, r_mm_done, r_illegal;
  logic [HALF_W-1:0]  r_res_data;
  logic [15:0]        r_mm_count;

  // Ops are only looked at while idle; anything presented during a stall is ignored.
  assign w_acc     = bus.op_valid && (r_state == S_IDLE);
  assign w_mm_last = (r_state == S_RUN) && (r_cnt == '0);

  // State and step-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state: matmul runs STEPS cycles, readC is request then capture.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_acc && bus.op_code == OP_MM) begin
          w_next     = S_RUN;
          w_cnt_next = CNT_W'(STEPS-1);
        end else if (w_acc && bus.op_code == OP_RDC) begin
          w_next = S_RDREQ;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) w_next = S_IDLE;
        else             w_cnt_next = r_cnt - 1'b1;
      end
      S_RDREQ: w_next = S_RDCAP;
      S_RDCAP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered strobes, row/data, result capture and matmul bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_we      <= 1'b0;
      r_b_we      <= 1'b0;
      r_c_we      <= 1'b0;
      r_step1     <= 1'b0;
      r_hl        <= 1'b0;
      r_row       <= '0;
      r_wdata     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_mm_done   <= 1'b0;
      r_illegal   <= 1'b0;
      r_mm_count  <= '0;
    end else begin
      r_a_we    <= 1'b0;
      r_b_we    <= 1'b0;
      r_c_we    <= 1'b0;
      r_step1   <= 1'b0;
      r_illegal <= 1'b0;
      if (w_acc) begin
        case (bus.op_code)
          OP_WRA, OP_WRB, OP_WRC: begin
            r_a_we  <= (bus.op_code == OP_WRA);
            r_b_we  <= (bus.op_code == OP_WRB);
            r_c_we  <= (bus.op_code == OP_WRC);
            r_row   <= bus.op_idx;
            r_wdata <= {bus.vec_hi, bus.vec_lo};
          end
          OP_STEP: r_step1 <= 1'b1;
          OP_RDC: begin
            r_row <= bus.op_idx;
            r_hl  <= bus.op_high_low;
          end
          OP_MM:   ;
          default: r_illegal <= 1'b1;
        endcase
      end
      r_mm_done <= w_mm_last;
      if (w_mm_last) r_mm_count <= r_mm_count + 16'd1;
      r_res_valid <= (r_state == S_RDCAP);
      // Array data is valid the cycle after arr_c_re, i.e. during RDCAP.
      if (r_state == S_RDCAP)
        r_res_data <= r_hl ? bus.arr_c_rdata[HALF_W +: HALF_W] : bus.arr_c_rdata[0 +: HALF_W];
    end
  end

  assign bus.op_ready   = (r_state == S_IDLE);
  assign bus.arr_a_we   = r_a_we;
  assign bus.arr_b_we   = r_b_we;
  assign bus.arr_c_we   = r_c_we;
  assign bus.arr_row    = r_row;
  assign bus.arr_wdata  = r_wdata;
  // Single steps are only issued from IDLE, so the two sources never overlap.
  assign bus.arr_step   = (r_state == S_RUN) | r_step1;
  assign bus.arr_c_re   = (r_state == S_RDREQ);
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.mm_done    = r_mm_done;
  assign bus.illegal_op = r_illegal;
  assign bus.mm_count   = r_mm_count;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: writes, matmul, readC, illegal/step, reset mid-run.
module tb_matmul_sequencer;
  localparam int DIM = 8, LANES = 4, DATA_W = 32, STEPS = 3*DIM-2;
  localparam int HALF_W = LANES*DATA_W, ROW_W = DIM*DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  matmul_sequencer_if #(.DIM(DIM), .LANES(LANES), .DATA_W(DATA_W)) bus ();

  matmul_sequencer #(.DIM(DIM), .LANES(LANES), .DATA_W(DATA_W), .STEPS(STEPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Array model: row 5 holds elements 0x10..0x17, returned the cycle after arr_c_re.
  always @(posedge clk) begin
    if (bus.arr_c_re) begin
      for (int j = 0; j < DIM; j++)
        bus.arr_c_rdata[j*DATA_W +: DATA_W] <= (bus.arr_row == 3'd5) ? 32'h10 + j : 32'hEE;
    end else begin
      bus.arr_c_rdata <= '0;
    end
  end

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ops();
    bus.op_valid = 1'b0; bus.op_code = 3'b000; bus.op_idx = '0; bus.op_high_low = 1'b0;
  endtask

  task automatic op(input logic [2:0] code, input logic [2:0] idx, input logic hl);
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_idx = idx; bus.op_high_low = hl;
  endtask

  logic [ROW_W-1:0]  exp_row;
  logic [HALF_W-1:0] exp_half;
  int                done_seen;

  initial begin
    idle_ops();
    bus.vec_lo = '0; bus.vec_hi = '0;

    // reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", ROW_W'(bus.op_ready), 1);
    chk("rst_strobes", ROW_W'({bus.arr_a_we, bus.arr_b_we, bus.arr_c_we, bus.arr_step, bus.arr_c_re}), 0);
    chk("rst_row", ROW_W'(bus.arr_row), 0);
    chk("rst_wdata", bus.arr_wdata, 0);
    chk("rst_res", ROW_W'({bus.res_valid, bus.res_data}), 0);
    chk("rst_flags", ROW_W'({bus.mm_done, bus.illegal_op}), 0);
    chk("rst_count", ROW_W'(bus.mm_count), 0);

    // writeA idx3, elements j+1
    for (int j = 0; j < LANES; j++) begin
      bus.vec_lo[j*DATA_W +: DATA_W] = 32'(j+1);
      bus.vec_hi[j*DATA_W +: DATA_W] = 32'(j+1+LANES);
    end
    for (int j = 0; j < DIM; j++) exp_row[j*DATA_W +: DATA_W] = 32'(j+1);
    op(3'b001, 3'd3, 1'b0);
    tick(); idle_ops();
    chk("wa_we", ROW_W'({bus.arr_a_we, bus.arr_b_we, bus.arr_c_we}), 3'b100);
    chk("wa_row", ROW_W'(bus.arr_row), 3);
    chk("wa_data", bus.arr_wdata, exp_row);
    chk("wa_ready", ROW_W'(bus.op_ready), 1);
    tick();
    chk("wa_we_off", ROW_W'({bus.arr_a_we, bus.arr_b_we, bus.arr_c_we}), 0);

    // back-to-back A, B, C
    op(3'b001, 3'd1, 1'b0); tick();
    chk("b2b_a", ROW_W'({bus.arr_a_we, bus.arr_b_we, bus.arr_c_we, bus.arr_row}), {3'b100, 3'd1});
    op(3'b010, 3'd2, 1'b0); tick();
    chk("b2b_b", ROW_W'({bus.arr_a_we, bus.arr_b_we, bus.arr_c_we, bus.arr_row}), {3'b010, 3'd2});
    op(3'b011, 3'd4, 1'b0); tick();
    chk("b2b_c", ROW_W'({bus.arr_a_we, bus.arr_b_we, bus.arr_c_we, bus.arr_row}), {3'b001, 3'd4});
    idle_ops(); tick();
    chk("b2b_off", ROW_W'({bus.arr_a_we, bus.arr_b_we, bus.arr_c_we}), 0);

    // op_valid low with a matmul code: nothing happens
    bus.op_code = 3'b100; tick();
    chk("novalid", ROW_W'({bus.op_ready, bus.arr_step}), 2'b10);
    idle_ops();

    // matmul: stall and step for 22 cycles, done at t+23
    op(3'b100, 3'd0, 1'b0); tick(); idle_ops();
    for (int i = 0; i < STEPS; i++) begin
      chk($sformatf("mm_run%0d", i), ROW_W'({bus.op_ready, bus.arr_step, bus.mm_done}), 3'b010);
      tick();
    end
    chk("mm_end", ROW_W'({bus.op_ready, bus.arr_step, bus.mm_done}), 3'b101);
    chk("mm_count1", ROW_W'(bus.mm_count), 1);
    tick();
    chk("mm_done_off", ROW_W'(bus.mm_done), 0);

    // readC idx5 high half
    op(3'b101, 3'd5, 1'b1); tick(); idle_ops();
    chk("rd_req", ROW_W'({bus.arr_c_re, bus.arr_row, bus.op_ready}), {1'b1, 3'd5, 1'b0});
    tick();
    chk("rd_cap", ROW_W'({bus.arr_c_re, bus.res_valid, bus.op_ready}), 3'b000);
    tick();
    for (int j = 0; j < LANES; j++) exp_half[j*DATA_W +: DATA_W] = 32'h14 + j;
    chk("rd_valid", ROW_W'({bus.res_valid, bus.op_ready}), 2'b11);
    chk("rd_data_hi", ROW_W'(bus.res_data), ROW_W'(exp_half));
    tick();
    chk("rd_hold", ROW_W'({bus.res_valid, bus.res_data}), ROW_W'({1'b0, exp_half}));

    // readC idx5 low half
    op(3'b101, 3'd5, 1'b0); tick(); idle_ops(); tick(); tick();
    for (int j = 0; j < LANES; j++) exp_half[j*DATA_W +: DATA_W] = 32'h10 + j;
    chk("rd_data_lo", ROW_W'({bus.res_valid, bus.res_data}), ROW_W'({1'b1, exp_half}));

    // illegal opcode, then single step
    op(3'b111, 3'd2, 1'b0); tick();
    chk("ill_pulse", ROW_W'({bus.illegal_op, bus.op_ready}), 2'b11);
    chk("ill_quiet", ROW_W'({bus.arr_a_we, bus.arr_b_we, bus.arr_c_we, bus.arr_step, bus.arr_c_re}), 0);
    op(3'b110, 3'd0, 1'b0); tick(); idle_ops();
    chk("step_pulse", ROW_W'({bus.illegal_op, bus.arr_step, bus.op_ready}), 3'b011);
    tick();
    chk("step_off", ROW_W'(bus.arr_step), 0);

    // reset during 10th RUN cycle of a matmul
    op(3'b100, 3'd0, 1'b0); tick(); idle_ops();
    for (int i = 0; i < 9; i++) tick();
    chk("rst_mid_run", ROW_W'({bus.arr_step, bus.op_ready}), 2'b10);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_after", ROW_W'({bus.arr_step, bus.op_ready}), 2'b01);
    chk("rst_mid_count", ROW_W'(bus.mm_count), 0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mm_done || bus.arr_step) done_seen++;
      tick();
    end
    chk("rst_mid_no_done", ROW_W'(done_seen), 0);
    chk("rst_mid_count2", ROW_W'(bus.mm_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
